exe_mem_req: RTL and testbench

Parametrised execute-stage memory request unit. It sits between the execute stage and the data-side SRAM-like bus (req/addr_ok/data_ok) and generalises the always-ready data SRAM port to a handshaked bus. It tracks up to MAX_OUT outstanding transactions and detects misaligned addresses (ALE). On a pipeline flush it cancels in-flight responses, so that late data_ok beats are discarded instead of being delivered to the next instruction.

---
 rtl/exe_mem_req_if.sv | 25 ++
 rtl/exe_mem_req.sv | 142 ++++++++++++++
 tb/tb_exe_mem_req.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_mem_req_if.sv
// rtl/exe_mem_req_if.sv - data-side SRAM-like bus between exe_mem_req and memory
interface exe_mem_req_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req;
    logic                    wr;
    logic [1:0]              size;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    addr_ok;
    logic                    data_ok;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/exe_mem_req.sv
// rtl/exe_mem_req.sv - execute-stage memory request unit with outstanding tracking and flush discard
module exe_mem_req #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_OUT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_store,
    input  logic [1:0]            op_size,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [DATA_WIDTH-1:0] op_wdata,
    input  logic                  flush,
    output logic                  ale,
    exe_mem_req_if.master         bus,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  busy
);
    localparam int         STRB_W  = DATA_WIDTH / 8;
    localparam int         LANE_W  = $clog2(STRB_W);
    localparam logic [2:0] CNT_MAX = 3'(MAX_OUT);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state;
    logic [2:0]            out_cnt;
    logic [2:0]            discard_cnt;
    logic                  req_kill;

    logic [LANE_W-1:0]     lane;
    logic                  misaligned;
    logic [STRB_W-1:0]     strb_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic                  addr_hs;
    logic                  beat;
    logic                  accept;
    logic [2:0]            out_nxt;
    logic [2:0]            disc_nxt;

    assign lane = op_addr[LANE_W-1:0];

    always_comb begin
        misaligned = 1'b0;
        strb_n     = '0;
        wdata_n    = '0;
        case (op_size)
            2'd0: begin
                strb_n  = STRB_W'(1) << lane;
                wdata_n = {STRB_W{op_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = op_addr[0];
                strb_n     = STRB_W'(3) << lane;
                wdata_n    = {(DATA_WIDTH/16){op_wdata[15:0]}};
            end
            2'd2: begin
                misaligned = |op_addr[1:0];
                strb_n     = STRB_W'(15) << lane;
                wdata_n    = {(DATA_WIDTH/32){op_wdata[31:0]}};
            end
            default: begin
                misaligned = (DATA_WIDTH == 32) | (|op_addr[2:0]);
                strb_n     = '1;
                wdata_n    = op_wdata;
            end
        endcase
        if (!op_store) strb_n = '0;
    end

    // A data_ok with nothing outstanding is a protocol violation and never counts.
    assign addr_hs = (state == REQ) & bus.addr_ok;
    assign beat    = bus.data_ok & (out_cnt != '0);
    assign out_nxt = out_cnt + {2'b00, addr_hs} - {2'b00, beat};

    always_comb begin
        if (flush) begin
            disc_nxt = out_nxt;
        end else begin
            disc_nxt = discard_cnt
                     - {2'b00, beat & (discard_cnt != '0)}
                     + {2'b00, addr_hs & req_kill};
        end
    end

    // A retiring beat frees a slot in the same cycle, so back-pressure lifts without a bubble.
    assign op_ready   = reset & (state == IDLE) & ((out_cnt < CNT_MAX) | beat) & ~flush;
    assign accept     = op_valid & op_ready;
    assign resp_valid = reset & beat & ~flush & (discard_cnt == '0);
    assign resp_rdata = bus.rdata;
    assign busy       = reset & ((out_cnt != '0) | (state == REQ));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            out_cnt     <= '0;
            discard_cnt <= '0;
            req_kill    <= 1'b0;
            ale         <= 1'b0;
            bus.req     <= 1'b0;
            bus.wr      <= 1'b0;
            bus.size    <= '0;
            bus.addr    <= '0;
            bus.wstrb   <= '0;
            bus.wdata   <= '0;
        end else begin
            out_cnt     <= out_nxt;
            discard_cnt <= disc_nxt;
            ale         <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            ale <= 1'b1;
                        end else begin
                            state     <= REQ;
                            bus.req   <= 1'b1;
                            bus.wr    <= op_store;
                            bus.size  <= op_size;
                            bus.addr  <= op_addr;
                            bus.wstrb <= strb_n;
                            bus.wdata <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    // Bus fields stay frozen until addr_ok even across a flush.
                    if (bus.addr_ok) begin
                        state    <= IDLE;
                        bus.req  <= 1'b0;
                        req_kill <= 1'b0;
                    end else if (flush) begin
                        req_kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_mem_req.sv
// tb/tb_exe_mem_req.sv - directed scoreboard bench for exe_mem_req (DATA_WIDTH=32, MAX_OUT=2)
module tb_exe_mem_req;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_store, flush;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        op_ready, ale, resp_valid, busy;
    logic [31:0] resp_rdata;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        valid;
        logic [31:0] rdata;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];

    exe_mem_req_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    exe_mem_req #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUT(2)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store),
        .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata),
        .flush(flush), .ale(ale), .bus(bus),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic aligned,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata);
        req_t r;
        op_valid = 1'b1; op_store = st; op_size = sz; op_addr = a; op_wdata = wd;
        #1;
        chk("op_ready_issue", op_ready, 1'b1);
        if (aligned) begin
            r.wr = st; r.size = sz; r.addr = a; r.wstrb = e_strb; r.wdata = e_wdata;
            exp_req.push_back(r);
        end
        tick();
        op_valid = 1'b0;
    endtask

    task automatic check_req(input string tag);
        req_t r;
        if (exp_req.size() == 0) begin
            vectors++; errs++;
            $error("FAIL %s observed=req expected=empty_scoreboard", tag);
        end else begin
            r = exp_req.pop_front();
            chk({tag, "_req"},   bus.req,   1'b1);
            chk({tag, "_wr"},    bus.wr,    r.wr);
            chk({tag, "_size"},  bus.size,  r.size);
            chk({tag, "_addr"},  bus.addr,  r.addr);
            chk({tag, "_wstrb"}, bus.wstrb, r.wstrb);
            chk({tag, "_wdata"}, bus.wdata, r.wdata);
        end
    endtask

    task automatic grant();
        bus.addr_ok = 1'b1;
        tick();
        bus.addr_ok = 1'b0;
    endtask

    task automatic respond(input string tag, input logic [31:0] rd,
                           input logic ck_rdy, input logic exp_rdy);
        resp_t e;
        bus.data_ok = 1'b1; bus.rdata = rd;
        #1;
        if (exp_resp.size() == 0) begin
            vectors++; errs++;
            $error("FAIL %s observed=data_ok expected=empty_scoreboard", tag);
        end else begin
            e = exp_resp.pop_front();
            chk({tag, "_valid"}, resp_valid, e.valid);
            if (e.valid) chk({tag, "_rdata"}, resp_rdata, e.rdata);
        end
        if (ck_rdy) chk({tag, "_ready"}, op_ready, exp_rdy);
        tick();
        bus.data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0;
        op_addr = '0; op_wdata = '0; flush = 1'b0;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
        tick(); tick();

        // Reset state, including derived outputs with live inputs.
        op_valid = 1'b1; bus.data_ok = 1'b1;
        #1;
        chk("rst_req", bus.req, 1'b0);     chk("rst_wr", bus.wr, 1'b0);
        chk("rst_ale", ale, 1'b0);         chk("rst_wstrb", bus.wstrb, 4'h0);
        chk("rst_addr", bus.addr, 32'h0);  chk("rst_wdata", bus.wdata, 32'h0);
        chk("rst_size", bus.size, 2'd0);   chk("rst_op_ready", op_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        op_valid = 1'b0; bus.data_ok = 1'b0;
        reset = 1'b1;
        tick();

        // Word store, addr_ok withheld for three cycles.
        issue(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        check_req("wst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wst_hold_req", bus.req, 1'b1);
            chk("wst_hold_addr", bus.addr, 32'h1000_0004);
            chk("wst_hold_wstrb", bus.wstrb, 4'b1111);
            chk("wst_hold_wdata", bus.wdata, 32'hDEAD_BEEF);
            chk("wst_hold_ready", op_ready, 1'b0);
        end
        grant();
        chk("wst_req_low", bus.req, 1'b0);
        chk("wst_out_cnt", dut.out_cnt, 3'd1);
        chk("wst_ready", op_ready, 1'b1);
        exp_resp.push_back('{1'b1, 32'h0});
        respond("wst_resp", 32'h0, 1'b0, 1'b0);
        chk("wst_out_done", dut.out_cnt, 3'd0);

        // Byte store lane 3 and half load lane 2.
        issue(1'b1, 2'd0, 32'h1000_0003, 32'h0000_005A, 1'b1, 4'b1000, 32'h5A5A_5A5A);
        check_req("bst");
        grant();
        exp_resp.push_back('{1'b1, 32'h0});
        respond("bst_resp", 32'h0, 1'b0, 1'b0);
        issue(1'b0, 2'd1, 32'h1000_0002, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000);
        check_req("hld");
        grant();
        exp_resp.push_back('{1'b1, 32'h1234_5678});
        respond("hld_resp", 32'h1234_5678, 1'b0, 1'b0);

        // Misaligned and illegal operations.
        issue(1'b0, 2'd1, 32'h1000_0001, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("ale_half", ale, 1'b1); chk("ale_half_req", bus.req, 1'b0);
        tick();
        chk("ale_half_off", ale, 1'b0); chk("ale_half_cnt", dut.out_cnt, 3'd0);
        issue(1'b1, 2'd2, 32'h1000_0002, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("ale_word", ale, 1'b1); chk("ale_word_req", bus.req, 1'b0);
        tick();
        chk("ale_word_off", ale, 1'b0); chk("ale_word_cnt", dut.out_cnt, 3'd0);
        issue(1'b0, 2'd3, 32'h1000_0000, 32'h0, 1'b0, 4'h0, 32'h0);
        chk("ale_dword", ale, 1'b1); chk("ale_dword_req", bus.req, 1'b0);
        tick();
        chk("ale_dword_off", ale, 1'b0); chk("ale_dword_cnt", dut.out_cnt, 3'd0);

        // Back-pressure at MAX_OUT outstanding.
        issue(1'b0, 2'd2, 32'h2000_0000, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("bp_a"); grant();
        issue(1'b0, 2'd2, 32'h2000_0004, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("bp_b"); grant();
        chk("bp_cnt", dut.out_cnt, 3'd2);
        op_valid = 1'b1; op_size = 2'd2; op_addr = 32'h2000_0008;
        #1;
        chk("bp_ready_low", op_ready, 1'b0);
        op_valid = 1'b0;
        exp_resp.push_back('{1'b1, 32'hAAAA_0001});
        respond("bp_resp_a", 32'hAAAA_0001, 1'b1, 1'b1);
        exp_resp.push_back('{1'b1, 32'hAAAA_0002});
        respond("bp_resp_b", 32'hAAAA_0002, 1'b0, 1'b0);

        // Flush with two loads outstanding; op_valid in the flush cycle is ignored.
        issue(1'b0, 2'd2, 32'h3000_0000, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("fl_a"); grant();
        issue(1'b0, 2'd2, 32'h3000_0004, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("fl_b"); grant();
        flush = 1'b1; op_valid = 1'b1; op_addr = 32'h3000_0008;
        #1;
        chk("fl_ready", op_ready, 1'b0);
        tick();
        flush = 1'b0; op_valid = 1'b0;
        chk("fl_discard", dut.discard_cnt, 3'd2);
        chk("fl_no_req", bus.req, 1'b0);
        exp_resp.push_back('{1'b0, 32'h0});
        exp_resp.push_back('{1'b0, 32'h0});
        respond("fl_drop_a", 32'hBAD0_0001, 1'b0, 1'b0);
        respond("fl_drop_b", 32'hBAD0_0002, 1'b0, 1'b0);
        chk("fl_discard_end", dut.discard_cnt, 3'd0);
        issue(1'b0, 2'd2, 32'h3000_000C, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("fl_c"); grant();
        exp_resp.push_back('{1'b1, 32'hC0DE_0003});
        respond("fl_resp_c", 32'hC0DE_0003, 1'b0, 1'b0);

        // Flush while in REQ; late addr_ok still counts but is discarded.
        issue(1'b0, 2'd0, 32'h4000_0001, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("rk");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rk_req_held", bus.req, 1'b1);
        chk("rk_kill", dut.req_kill, 1'b1);
        tick();
        chk("rk_req_held2", bus.req, 1'b1);
        chk("rk_addr_held", bus.addr, 32'h4000_0001);
        grant();
        chk("rk_out", dut.out_cnt, 3'd1);
        chk("rk_discard", dut.discard_cnt, 3'd1);
        chk("rk_kill_clr", dut.req_kill, 1'b0);
        exp_resp.push_back('{1'b0, 32'h0});
        respond("rk_drop", 32'hBAD0_0004, 1'b0, 1'b0);

        // Reset mid-REQ with one transaction outstanding.
        issue(1'b0, 2'd2, 32'h5000_0000, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("mr_a"); grant();
        issue(1'b0, 2'd2, 32'h5000_0004, 32'h0, 1'b1, 4'h0, 32'h0);
        check_req("mr_b");
        reset = 1'b0;
        tick();
        chk("mr_req", bus.req, 1'b0);
        chk("mr_out", dut.out_cnt, 3'd0);
        chk("mr_discard", dut.discard_cnt, 3'd0);
        chk("mr_busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        chk("mr_idle_ready", op_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
